// File: rtl/instr_pkg.sv
// Shared definitions for the instruction sequencer: opcodes, sequencer states
// and instruction-word field layout.
package instr_pkg;

    localparam int INSTR_W    = 16;
    localparam int OPC_W      = 4;
    localparam int OPC_LSB    = 12;
    localparam int OPERAND_W  = 8;
    localparam int OPERAND_LSB = 0;
    localparam int ALU_OP_W   = 3;

    typedef enum logic [OPC_W-1:0] {
        OP_NOP  = 4'h0,
        OP_JMP  = 4'h1,
        OP_BZ   = 4'h2,
        OP_CALL = 4'h3,
        OP_RET  = 4'h4,
        OP_ALU  = 4'h8,
        OP_HALT = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_FETCH,
        ST_EXEC,
        ST_ALU,
        ST_HALT
    } seq_state_e;

    // 0x8..0xE are ALU operations; 0xF shares the top bit but is HALT.
    function automatic logic is_alu(input logic [OPC_W-1:0] opc);
        return (opc >= OP_ALU) && (opc != OP_HALT);
    endfunction

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO with registered count; top of stack is read
// combinationally so RET can branch in its single EXEC cycle.
module ret_stack #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]   mem [DEPTH];
    logic [PTR_W:0] count;
    logic [PTR_W-1:0] top;

    assign full  = (count == (PTR_W+1)'(DEPTH));
    assign empty = (count == '0);
    assign top   = PTR_W'(count - 1'b1);
    assign dout  = mem[top];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count <= '0;
        end else if (push && !full) begin
            count <= count + 1'b1;
        end else if (pop && !empty) begin
            count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[count[PTR_W-1:0]] <= din;
        end
    end

endmodule

// File: rtl/instr_seq.sv
// Multi-cycle instruction sequencer: fetches over req/ack, executes control
// flow locally with a return stack, and issues ALU ops over valid/ready.
module instr_seq
    import instr_pkg::*;
#(
    parameter int STACK_DEPTH = 4,
    parameter int ADDR_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pc_value,
    output logic              pc_step,
    output logic              pc_branch,
    output logic [ADDR_W-1:0] pc_target,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [15:0]       imem_data,
    input  logic              zero_flag,
    output logic              alu_valid,
    input  logic              alu_ready,
    output logic [2:0]        alu_op,
    output logic [7:0]        alu_operand,
    output logic              halted,
    output logic              error
);

    seq_state_e state, state_next;

    logic [INSTR_W-1:0]   ir;
    logic [OPC_W-1:0]     opc;
    logic [OPERAND_W-1:0] operand;
    logic                 unused_ir_bits;

    logic              push, pop, stack_err;
    logic              full, empty;
    logic [ADDR_W-1:0] stack_top;
    logic              err_q;

    assign opc            = ir[OPC_LSB +: OPC_W];
    assign operand        = ir[OPERAND_LSB +: OPERAND_W];
    assign unused_ir_bits = ^ir[11:8];
    assign error          = err_q;

    ret_stack #(
        .DEPTH (STACK_DEPTH),
        .W     (ADDR_W)
    ) u_ret_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (ADDR_W'(pc_value + 1'b1)),
        .dout  (stack_top),
        .full  (full),
        .empty (empty)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_FETCH;
            ir    <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            if (state == ST_FETCH && imem_ack) begin
                ir <= imem_data;
            end
            if (stack_err) begin
                err_q <= 1'b1;
            end
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_FETCH: if (imem_ack) state_next = ST_EXEC;
            ST_EXEC: begin
                if (is_alu(opc)) begin
                    state_next = ST_ALU;
                end else begin
                    case (opc)
                        OP_CALL: state_next = full  ? ST_HALT : ST_FETCH;
                        OP_RET:  state_next = empty ? ST_HALT : ST_FETCH;
                        OP_HALT: state_next = ST_HALT;
                        default: state_next = ST_FETCH;
                    endcase
                end
            end
            ST_ALU:  if (alu_ready) state_next = ST_FETCH;
            ST_HALT: state_next = ST_HALT;
            default: state_next = ST_FETCH;
        endcase
    end

    // Outputs are gated by rst so they drop as soon as reset asserts,
    // even though the state register already sits in FETCH.
    always_comb begin
        pc_step     = 1'b0;
        pc_branch   = 1'b0;
        pc_target   = '0;
        imem_req    = 1'b0;
        imem_addr   = '0;
        alu_valid   = 1'b0;
        alu_op      = '0;
        alu_operand = '0;
        halted      = 1'b0;
        push        = 1'b0;
        pop         = 1'b0;
        stack_err   = 1'b0;
        if (rst) begin
            case (state)
                ST_FETCH: begin
                    imem_req  = 1'b1;
                    imem_addr = pc_value;
                end
                ST_EXEC: begin
                    if (!is_alu(opc)) begin
                        case (opc)
                            OP_JMP: begin
                                pc_branch = 1'b1;
                                pc_target = ADDR_W'(operand);
                            end
                            OP_BZ: begin
                                if (zero_flag) begin
                                    pc_branch = 1'b1;
                                    pc_target = ADDR_W'(operand);
                                end else begin
                                    pc_step = 1'b1;
                                end
                            end
                            OP_CALL: begin
                                if (!full) begin
                                    push      = 1'b1;
                                    pc_branch = 1'b1;
                                    pc_target = ADDR_W'(operand);
                                end else begin
                                    stack_err = 1'b1;
                                end
                            end
                            OP_RET: begin
                                if (!empty) begin
                                    pop       = 1'b1;
                                    pc_branch = 1'b1;
                                    pc_target = stack_top;
                                end else begin
                                    stack_err = 1'b1;
                                end
                            end
                            OP_HALT: ;
                            default: pc_step = 1'b1;
                        endcase
                    end
                end
                ST_ALU: begin
                    alu_valid   = 1'b1;
                    alu_op      = opc[ALU_OP_W-1:0];
                    alu_operand = operand;
                    pc_step     = alu_ready;
                end
                ST_HALT: halted = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_seq.sv
// Directed bench for instr_seq: a small PC model follows pc_step/pc_branch,
// each instruction is fed by hand with hand-computed expectations.
module tb_instr_seq;

    logic        clk;
    logic        rst;
    logic [7:0]  pc;
    logic        pc_step, pc_branch;
    logic [7:0]  pc_target;
    logic        imem_req;
    logic [7:0]  imem_addr;
    logic        imem_ack;
    logic [15:0] imem_data;
    logic        zero_flag;
    logic        alu_valid, alu_ready;
    logic [2:0]  alu_op;
    logic [7:0]  alu_operand;
    logic        halted, error;

    int n_total = 0;
    int n_pass  = 0;

    instr_seq #(
        .STACK_DEPTH (4),
        .ADDR_W      (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .pc_value    (pc),
        .pc_step     (pc_step),
        .pc_branch   (pc_branch),
        .pc_target   (pc_target),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_data   (imem_data),
        .zero_flag   (zero_flag),
        .alu_valid   (alu_valid),
        .alu_ready   (alu_ready),
        .alu_op      (alu_op),
        .alu_operand (alu_operand),
        .halted      (halted),
        .error       (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Program counter environment model.
    always @(posedge clk or negedge rst) begin
        if (!rst) pc <= 8'h00;
        else if (pc_branch) pc <= pc_target;
        else if (pc_step) pc <= pc + 8'h01;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    // Fetch with dly cycles of ack latency; returns just after the edge into EXEC.
    task automatic fetch(input logic [15:0] d, input int dly, input logic [7:0] addr);
        imem_data = d;
        imem_ack  = 1'b0;
        for (int i = 0; i < dly; i++) begin
            @(negedge clk);
            check("fetch_wait_req", imem_req, 1);
            check("fetch_wait_addr", imem_addr, addr);
            @(posedge clk); #1;
        end
        imem_ack = 1'b1;
        @(negedge clk);
        check("fetch_req", imem_req, 1);
        check("fetch_addr", imem_addr, addr);
        @(posedge clk); #1;
        imem_ack = 1'b0;
    endtask

    task automatic exec(input logic step, input logic branch, input logic [7:0] tgt);
        @(negedge clk);
        check("exec_req", imem_req, 0);
        check("exec_step", pc_step, step);
        check("exec_branch", pc_branch, branch);
        if (branch) check("exec_target", pc_target, tgt);
        @(posedge clk); #1;
    endtask

    task automatic reset_pulse;
        rst = 1'b0;
        #1;
        check("rst_req", imem_req, 0);
        check("rst_halted", halted, 0);
        check("rst_error", error, 0);
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    initial begin
        rst       = 1'b0;
        imem_ack  = 1'b0;
        imem_data = 16'h0000;
        zero_flag = 1'b0;
        alu_ready = 1'b0;

        // Reset values
        #12;
        check("reset_req", imem_req, 0);
        check("reset_addr", imem_addr, 0);
        check("reset_step", pc_step, 0);
        check("reset_branch", pc_branch, 0);
        check("reset_alu_valid", alu_valid, 0);
        check("reset_halted", halted, 0);
        check("reset_error", error, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // NOP, NOP, reserved 0x5 -> all step
        fetch(16'h0000, 0, 8'h00); exec(1, 0, 8'h00);
        fetch(16'h0000, 0, 8'h01); exec(1, 0, 8'h00);
        fetch(16'h5000, 0, 8'h02); exec(1, 0, 8'h00);

        // JMP 0x42 with 3-cycle ack delay
        fetch(16'h1042, 3, 8'h03); exec(0, 1, 8'h42);

        // BZ taken then not taken
        zero_flag = 1'b1;
        fetch(16'h2010, 0, 8'h42); exec(0, 1, 8'h10);
        zero_flag = 1'b0;
        fetch(16'h2010, 0, 8'h10); exec(1, 0, 8'h00);

        // CALL at 0x05 then RET -> 0x06
        fetch(16'h1005, 0, 8'h11); exec(0, 1, 8'h05);
        fetch(16'h3080, 0, 8'h05); exec(0, 1, 8'h80);
        fetch(16'h4000, 0, 8'h80); exec(0, 1, 8'h06);

        // ALU 0x9A07 with ready low for 2 cycles
        fetch(16'h9A07, 0, 8'h06); exec(0, 0, 8'h00);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("alu_valid_wait", alu_valid, 1);
            check("alu_op", alu_op, 3'd1);
            check("alu_operand", alu_operand, 8'h07);
            check("alu_step_wait", pc_step, 0);
            @(posedge clk); #1;
        end
        alu_ready = 1'b1;
        @(negedge clk);
        check("alu_valid_rdy", alu_valid, 1);
        check("alu_step_rdy", pc_step, 1);
        @(posedge clk); #1;
        alu_ready = 1'b0;

        // Wrap: CALL at 0xFF pushes 0x00
        fetch(16'h10FF, 0, 8'h07); exec(0, 1, 8'hFF);
        fetch(16'h3020, 0, 8'hFF); exec(0, 1, 8'h20);
        fetch(16'h4000, 0, 8'h20); exec(0, 1, 8'h00);

        // Leave an entry on the stack, then reset mid-ALU
        fetch(16'h3030, 0, 8'h00); exec(0, 1, 8'h30);
        fetch(16'h8000, 0, 8'h30); exec(0, 0, 8'h00);
        @(negedge clk);
        check("midalu_valid", alu_valid, 1);
        #1 rst = 1'b0;
        #1;
        check("midalu_rst_valid", alu_valid, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Reset mid-FETCH
        imem_ack = 1'b0;
        @(negedge clk);
        check("midfetch_req", imem_req, 1);
        #1 rst = 1'b0;
        #1;
        check("midfetch_rst_req", imem_req, 0);
        @(posedge clk); #1;
        rst = 1'b1;

        // Stack emptied by reset: RET underflows into HALT
        fetch(16'h4000, 0, 8'h00); exec(0, 0, 8'h00);
        imem_ack = 1'b1;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("uflow_halted", halted, 1);
            check("uflow_error", error, 1);
            check("uflow_req", imem_req, 0);
            @(posedge clk); #1;
        end
        imem_ack = 1'b0;

        // HALT opcode: halts without error
        reset_pulse();
        fetch(16'hF000, 0, 8'h00); exec(0, 0, 8'h00);
        @(negedge clk);
        check("halt_halted", halted, 1);
        check("halt_error", error, 0);
        check("halt_req", imem_req, 0);
        @(posedge clk); #1;

        // Four nested CALLs succeed, fifth overflows
        reset_pulse();
        fetch(16'h3001, 0, 8'h00); exec(0, 1, 8'h01);
        fetch(16'h3002, 0, 8'h01); exec(0, 1, 8'h02);
        fetch(16'h3003, 0, 8'h02); exec(0, 1, 8'h03);
        fetch(16'h3004, 0, 8'h03); exec(0, 1, 8'h04);
        fetch(16'h3010, 0, 8'h04); exec(0, 0, 8'h00);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("oflow_halted", halted, 1);
            check("oflow_error", error, 1);
            check("oflow_req", imem_req, 0);
            check("oflow_pc", pc, 8'h04);
            @(posedge clk); #1;
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/instr_seq.md
Name: instr_seq

Overview:
- Multi-cycle instruction sequencer that owns the program-counter control lines (step, branch, target).
- Each instruction is fetched over a req/ack memory handshake, decoded, and then handled locally (jump/branch/call/return/halt) or issued to the ALU over valid/ready.
- Holds a small return-address stack for CALL/RET.
- Sits between the 8-bit program counter, instruction memory and ALU in the core.

Parameters:
- STACK_DEPTH, 4, number of return-address entries (power of two, ≥2).
- ADDR_W, 8, instruction address width.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset
- pc_value  in  ADDR_W  current PC
- pc_step  out  1  PC increments at next edge
- pc_branch  out  1  PC loads pc_target at next edge (dominates pc_step)
- pc_target  out  ADDR_W  branch destination
- imem_req  out  1  fetch request
- imem_addr  out  ADDR_W  fetch address
- imem_ack  in  1  fetch data valid this cycle
- imem_data  in  16  instruction word: [15:12] opcode, [7:0] operand
- zero_flag  in  1  ALU zero flag, sampled in EXEC
- alu_valid  out  1  ALU issue request
- alu_ready  in  1  ALU accepts the issue
- alu_op  out  3  ALU operation, opcode[2:0]
- alu_operand  out  8  ALU immediate
- halted  out  1  sticky halt indicator
- error  out  1  sticky stack overflow/underflow indicator

Behaviour:
- PC contract: the PC holds unless pc_step or pc_branch is high. pc_step and pc_branch are never both high.
- Reset (async, rst=0):
  - State goes to FETCH.
  - Stack pointer goes to 0 (empty).
  - Instruction register goes to 0.
  - All outputs go to 0 immediately, including imem_req.
  - A transaction cut off by reset is abandoned. A late ack after reset release is ignored unless FETCH is requesting.
- FETCH:
  - imem_req=1, imem_addr=pc_value; both held stable until ack.
  - On imem_ack=1: capture imem_data into IR, go to EXEC. Ack can arrive in the first FETCH cycle.
- EXEC (one cycle), by opcode:
  - 0x0 NOP, or 0x5–0x7 (reserved): pc_step=1, go to FETCH.
  - 0x1 JMP: pc_branch=1, pc_target=operand, go to FETCH.
  - 0x2 BZ: if zero_flag=1, branch to operand; otherwise pc_step=1. Go to FETCH.
  - 0x3 CALL, stack not full: push (pc_value+1) mod 2^ADDR_W, branch to operand, go to FETCH.
  - 0x3 CALL, stack full: error=1, go to HALT. No push, no PC change.
  - 0x4 RET, stack not empty: pop, pc_target=popped value, pc_branch=1, go to FETCH.
  - 0x4 RET, stack empty: error=1, go to HALT.
  - 0x8–0xE ALU: go to ALU.
  - 0xF HALT: go to HALT, PC unchanged.
- ALU state:
  - alu_valid=1; alu_op and alu_operand come from IR and are stable while waiting.
  - On alu_ready=1: pc_step=1 in the same cycle, go to FETCH.
- HALT:
  - halted=1, all requests 0.
  - Only reset leaves HALT. error stays sticky.
- Stack:
  - Full when count==STACK_DEPTH; empty when count==0.
  - Only one push or pop per cycle; CALL and RET are never simultaneous by construction.
- Timing: minimum 2 cycles per non-ALU instruction (ack in first FETCH cycle); minimum 3 cycles for ALU instructions.
- Address arithmetic wraps modulo 2^ADDR_W: CALL at 0xFF pushes 0x00.

Decomposition:
- Package instr_pkg:
  - opcode_e enum: NOP, JMP, BZ, CALL, RET, ALU range base, HALT.
  - seq_state_e enum: FETCH, EXEC, ALU, HALT.
  - Instruction field positions and width constants.
- Sub-module ret_stack:
  - Parameterised LIFO (push, pop, din, dout, full, empty, async active-low rst).
  - Instantiated once.

Test Plan:
- Reset, then imem_data=0x0000 acked immediately -> imem_req=1 with imem_addr=0x00 in cycle 1; pc_step=1 in cycle 2; repeats every 2 cycles.
- JMP 0x1042 with ack delayed 3 cycles -> imem_addr held for 4 cycles; then pc_branch=1, pc_target=0x42 for one cycle.
- BZ 0x2010 with zero_flag=1 -> branch to 0x10; repeat with zero_flag=0 -> pc_step=1, no branch.
- CALL 0x3080 at pc 0x05, then RET -> push 0x06; RET gives pc_branch=1, pc_target=0x06. Four nested CALLs succeed; the fifth sets error=1, halted=1, and no further imem_req.
- ALU 0x9A07 with alu_ready low for 2 cycles -> alu_valid=1, alu_op=1, alu_operand=0x07 for 3 cycles; pc_step only on the ready cycle.
- rst pulled low mid-FETCH and mid-ALU -> imem_req and alu_valid drop asynchronously; after release, fetch restarts and stack is empty (RET sets error=1).
